decode_alu3: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu3_decode_comb.sv | 21 ++
 rtl/decode_alu3.sv | 40 ++++
 tb/tb_decode_alu3.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control-word encodings: op class codes and opcode constants.
// Control words are packed {Ctrl0,Ctrl1,Ctrl2,Ctrl3,Ctrl4,Ctrl5}, Ctrl0 in the MSB.
package alu_ctrl_pkg;

    typedef logic [5:0] ctrl_word_t;
    typedef logic [1:0] op_class_t;

    localparam op_class_t CLS_ALU   = 2'b00;
    localparam op_class_t CLS_ARITH = 2'b01;
    localparam op_class_t CLS_SHIFT = 2'b10;
    localparam op_class_t CLS_RSVD  = 2'b11;

    // Arithmetic ops
    localparam ctrl_word_t OP_ADD = 6'b010010;
    localparam ctrl_word_t OP_SUB = 6'b010001;
    localparam ctrl_word_t OP_INC = 6'b011011;
    localparam ctrl_word_t OP_DEC = 6'b011000;

    // Logic / move ops
    localparam ctrl_word_t OP_OR  = 6'b001010;
    localparam ctrl_word_t OP_NOT = 6'b001100;
    localparam ctrl_word_t OP_XOR = 6'b001110;
    localparam ctrl_word_t OP_AND = 6'b000110;
    localparam ctrl_word_t OP_MOV = 6'b000000;

    // Shifts and rotates
    localparam ctrl_word_t OP_SLL = 6'b100000;
    localparam ctrl_word_t OP_SLA = 6'b100100;
    localparam ctrl_word_t OP_SRL = 6'b101000;
    localparam ctrl_word_t OP_SRA = 6'b101100;
    localparam ctrl_word_t OP_ROL = 6'b100010;
    localparam ctrl_word_t OP_ROR = 6'b101010;

    function automatic op_class_t op_class(input ctrl_word_t w);
        return w[5:4];
    endfunction

endpackage

// File: rtl/alu3_decode_comb.sv
// Pure combinational ALU3 carry-in / shift-in decode of a control word and carry flag.
// Zero latency, no flow control.
module alu3_decode_comb
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] ctrl_word_i,
    input  logic       c_flag_i,
    output logic       d_o
);

    // Arithmetic takes its carry-in from Ctrl5; rotates (Ctrl4) pass the stored carry.
    always_comb begin
        d_o = 1'b0;
        casez (ctrl_word_i)
            {CLS_ARITH, 4'b???1}: d_o = 1'b1;
            {CLS_SHIFT, 4'b??1?}: d_o = c_flag_i;
            default:              d_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_alu3.sv
// ALU bit-3 control decoder: registered carry-in / shift-in bit for the datapath.
// One-cycle latency, new control word every cycle, no backpressure.
module decode_alu3
    import alu_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic Ctrl0,
    input  logic Ctrl1,
    input  logic Ctrl2,
    input  logic Ctrl3,
    input  logic Ctrl4,
    input  logic Ctrl5,
    input  logic c_flag,
    output logic ALU3_out
);

    ctrl_word_t ctrl_word;
    logic       alu3_d;
    logic       alu3_q;

    assign ctrl_word = {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5};

    alu3_decode_comb u_decode (
        .ctrl_word_i (ctrl_word),
        .c_flag_i    (c_flag),
        .d_o         (alu3_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu3_q <= 1'b0;
        end else begin
            alu3_q <= alu3_d;
        end
    end

    assign ALU3_out = alu3_q;

endmodule

// File: tb/tb_decode_alu3.sv
// Directed-vector bench for decode_alu3, plus a 128-code sweep against a small model.
module tb_decode_alu3;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5;
    logic c_flag;
    logic ALU3_out;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q = 1'b0;

    decode_alu3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Ctrl0    (Ctrl0),
        .Ctrl1    (Ctrl1),
        .Ctrl2    (Ctrl2),
        .Ctrl3    (Ctrl3),
        .Ctrl4    (Ctrl4),
        .Ctrl5    (Ctrl5),
        .c_flag   (c_flag),
        .ALU3_out (ALU3_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: ALU3_out=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] w, input logic cf);
        {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5} = w;
        c_flag = cf;
    endtask

    // Drive on the falling edge, confirm the output has not moved yet, then check after the rising edge.
    task automatic step(input string tag, input logic [5:0] w, input logic cf, input logic exp);
        @(negedge clk);
        drive(w, cf);
        #1;
        chk({tag, "_hold"}, ALU3_out, exp_q);
        @(posedge clk);
        #1;
        chk(tag, ALU3_out, exp);
        exp_q = exp;
    endtask

    function automatic logic model(input logic [5:0] w, input logic cf);
        logic c0, c1, c4, c5;
        {c0, c1} = w[5:4];
        c4 = w[1];
        c5 = w[0];
        return (!c0 && c1 && c5) || (c0 && !c1 && c4 && cf);
    endfunction

    initial begin
        rst_n = 1'b1;
        drive(OP_SUB, 1'b0);

        // Load a 1 so the asynchronous clear is visible.
        @(posedge clk);
        #1;
        exp_q = 1'b1;
        chk("pre_reset_sub", ALU3_out, 1'b1);

        // Test 1: reset clears at once and holds for two edges.
        @(negedge clk);
        rst_n = 1'b0;
        drive(OP_ROL, 1'b1);
        #1;
        chk("reset_async", ALU3_out, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_2cyc", ALU3_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_SUB, 1'b0);
        #1;
        chk("release_no_edge", ALU3_out, 1'b0);
        exp_q = 1'b0;
        @(posedge clk);
        #1;
        chk("release_first_edge", ALU3_out, 1'b1);
        exp_q = 1'b1;

        // Test 2: SUB then ADD on consecutive edges.
        step("sub", OP_SUB, 1'b0, 1'b1);
        step("add", OP_ADD, 1'b0, 1'b0);

        // Test 3: INC / DEC ignore c_flag.
        step("inc_cf0", OP_INC, 1'b0, 1'b1);
        step("dec_cf1", OP_DEC, 1'b1, 1'b0);
        step("inc_cf1", OP_INC, 1'b1, 1'b1);
        step("dec_cf0", OP_DEC, 1'b0, 1'b0);
        step("add_cf1", OP_ADD, 1'b1, 1'b0);

        // Test 4: rotates pass c_flag sampled with the code.
        step("rol_cf1", OP_ROL, 1'b1, 1'b1);
        step("rol_cf0", OP_ROL, 1'b0, 1'b0);
        step("ror_cf1", OP_ROR, 1'b1, 1'b1);
        step("ror_cf0", OP_ROR, 1'b0, 1'b0);

        // Test 5: logic ops and plain shifts give 0 even with carry set.
        step("rol_pre", OP_ROL, 1'b1, 1'b1);
        step("or",  OP_OR,  1'b1, 1'b0);
        step("not", OP_NOT, 1'b1, 1'b0);
        step("xor", OP_XOR, 1'b1, 1'b0);
        step("and", OP_AND, 1'b1, 1'b0);
        step("mov", OP_MOV, 1'b1, 1'b0);
        step("sla", OP_SLA, 1'b1, 1'b0);
        step("sll", OP_SLL, 1'b1, 1'b0);
        step("sra", OP_SRA, 1'b1, 1'b0);
        step("srl", OP_SRL, 1'b1, 1'b0);
        step("rsvd_cin", 6'b110011, 1'b1, 1'b0);
        step("rsvd_all", 6'b111111, 1'b1, 1'b0);

        // Test 6: mid-cycle reset after a 1, then recovery.
        step("sub_pre_rst", OP_SUB, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcycle_reset", ALU3_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midcycle_release", ALU3_out, 1'b0);
        exp_q = 1'b0;
        @(posedge clk);
        #1;
        chk("sub_after_release", ALU3_out, 1'b1);
        exp_q = 1'b1;

        // Exhaustive sweep of {Ctrl0..Ctrl5, c_flag}.
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            step($sformatf("sweep_%02h", i), v[6:1], v[0], model(v[6:1], v[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
